adder8: RTL and testbench

//   8-bit binary adder with carry-in/carry-out and a registered output stage.

---
 rtl/adder8.sv | 62 ++++++
 tb/tb_adder8.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/adder8.sv
// adder8: 8-bit two-nibble carry-lookahead adder with a registered, valid-qualified output stage.
// Define ADDER8_OVERFLOW_EN to add the registered two's-complement overflow output.
module adder8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] operand1,
  input  logic [7:0] operand2,
  input  logic       carry_in,
  output logic       out_valid,
  output logic [7:0] result,
`ifdef ADDER8_OVERFLOW_EN
  output logic       overflow,
`endif
  output logic       carry_out
);
  logic [7:0] g, p, s;
  logic [8:0] c;
  logic [7:0] result_d, result_q;
  logic       carry_d, carry_q, valid_q;
  function automatic logic [3:0] cla4(input logic [3:0] gn, input logic [3:0] pn, input logic ci);
    cla4[0] = gn[0] | (pn[0] & ci);
    cla4[1] = gn[1] | (pn[1] & gn[0]) | (pn[1] & pn[0] & ci);
    cla4[2] = gn[2] | (pn[2] & gn[1]) | (pn[2] & pn[1] & gn[0]) | (pn[2] & pn[1] & pn[0] & ci);
    cla4[3] = gn[3] | (pn[3] & gn[2]) | (pn[3] & pn[2] & gn[1]) | (pn[3] & pn[2] & pn[1] & gn[0])
            | (pn[3] & pn[2] & pn[1] & pn[0] & ci);
  endfunction
  assign g = operand1 & operand2;
  assign p = operand1 ^ operand2;
  assign c[0] = carry_in;
  assign c[4:1] = cla4(g[3:0], p[3:0], c[0]);
  // c4 is the group carry feeding the high nibble
  assign c[8:5] = cla4(g[7:4], p[7:4], c[4]);
  assign s = p ^ c[7:0];
  always_comb begin
    result_d = in_valid ? s : result_q;
    carry_d  = in_valid ? c[8] : carry_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= 8'h00;
      carry_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
      valid_q  <= in_valid;
    end
  end
`ifdef ADDER8_OVERFLOW_EN
  logic ovf_d, ovf_q;
  always_comb ovf_d = in_valid ? (c[7] ^ c[8]) : ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
  end
  assign overflow = ovf_q;
`endif
  assign result    = result_q;
  assign carry_out = carry_q;
  assign out_valid = valid_q;
endmodule

// File: tb/tb_adder8.sv
// tb_adder8: directed and randomized checks of adder8 against an arithmetic reference model.
`timescale 1ns/100ps
module tb_adder8;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       carry_in = 1'b0;
  logic [7:0] operand1 = 8'h00;
  logic [7:0] operand2 = 8'h00;
  logic       out_valid, carry_out;
  logic [7:0] result;
`ifdef ADDER8_OVERFLOW_EN
  logic       overflow;
`endif
  int   checks = 0;
  int   errors = 0;
  bit   rnd_on = 1'b0;
  logic [7:0] exp_r = 8'h00;
  logic       exp_c = 1'b0, exp_v = 1'b0, exp_o = 1'b0;

  always #5 clk = ~clk;

  adder8 dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .operand1(operand1),
    .operand2(operand2),
    .carry_in(carry_in),
    .out_valid(out_valid),
    .result(result),
`ifdef ADDER8_OVERFLOW_EN
    .overflow(overflow),
`endif
    .carry_out(carry_out)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".result"}, result, exp_r);
    chk({tag, ".carry_out"}, {7'b0, carry_out}, {7'b0, exp_c});
    chk({tag, ".out_valid"}, {7'b0, out_valid}, {7'b0, exp_v});
`ifdef ADDER8_OVERFLOW_EN
    chk({tag, ".overflow"}, {7'b0, overflow}, {7'b0, exp_o});
`endif
  endtask

  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic v);
    int usum, ssum;
    if (v) begin
      usum  = int'(a) + int'(b) + int'(ci);
      ssum  = int'($signed(a)) + int'($signed(b)) + int'(ci);
      exp_r = usum[7:0];
      exp_c = usum > 255;
      exp_o = (ssum > 127) || (ssum < -128);
    end
    exp_v = v;
  endtask

  task automatic model_reset();
    exp_r = 8'h00;
    exp_c = 1'b0;
    exp_v = 1'b0;
    exp_o = 1'b0;
  endtask

  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic v,
                      input string tag);
    @(negedge clk);
    operand1 = a;
    operand2 = b;
    carry_in = ci;
    in_valid = v;
    @(posedge clk);
    #1;
    model(a, b, ci, v);
    check_all(tag);
  endtask

  initial begin
    logic [7:0] a, b;
    logic       ci, v;
    in_valid = 1'b1;
    operand1 = 8'($urandom);
    operand2 = 8'($urandom);
    carry_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h00, 8'h00, 1'b0, 1'b1, "zero");
    step(8'hFF, 8'h01, 1'b0, 1'b1, "wrap");
    step(8'h0F, 8'h00, 1'b1, 1'b1, "group_carry");
    step(8'h7F, 8'h01, 1'b0, 1'b1, "ovf_pos");
    step(8'h80, 8'h80, 1'b0, 1'b1, "ovf_neg");
    step(8'hFF, 8'hFF, 1'b1, 1'b1, "max");
    step(8'h12, 8'h34, 1'b1, 1'b1, "b2b_0");
    step(8'hF0, 8'h20, 1'b0, 1'b1, "b2b_1");
    step(8'hxx, 8'hxx, 1'bx, 1'b0, "hold_x0");
    step(8'hxx, 8'hxx, 1'bx, 1'b0, "hold_x1");
    step(8'h55, 8'hAA, 1'b1, 1'b1, "pre_rst");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h01, 8'h02, 1'b0, 1'b1, "post_rst");
    @(posedge clk);
    #0.5;
    rnd_on = 1'b1;
    fork
      while (rnd_on) begin #3; operand1 = 8'($urandom); end
      while (rnd_on) begin #5; operand2 = 8'($urandom); end
      while (rnd_on) begin #7; carry_in = 1'($urandom); end
      while (rnd_on) begin #4; in_valid = ($urandom_range(3, 0) != 0); end
    join_none
    repeat (300) begin
      @(posedge clk);
      a  = operand1;
      b  = operand2;
      ci = carry_in;
      v  = in_valid;
      #1;
      model(a, b, ci, v);
      check_all("rand");
    end
    rnd_on = 1'b0;
    #20;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
